// File: rtl/country_sensor_cond_pkg.sv
// -----------------------------------------------------------------------------
// country_sensor_cond_pkg
// Shared definitions for the country-road vehicle-detector conditioner.
//   - Request FSM state encodings (also visible on the req_state debug port).
//   - Light-colour codes used by the highway/country controller. A top that
//     receives the controller's 2-bit country colour can derive cntry_green
//     with is_green().
// -----------------------------------------------------------------------------
package country_sensor_cond_pkg;

    // Request FSM states
    localparam logic [1:0] ST_IDLE    = 2'b00;
    localparam logic [1:0] ST_ARMED   = 2'b01;
    localparam logic [1:0] ST_REQUEST = 2'b10;
    localparam logic [1:0] ST_HOLD    = 2'b11;

    // Controller light colours
    localparam logic [1:0] COLOUR_RED    = 2'b00;
    localparam logic [1:0] COLOUR_YELLOW = 2'b01;
    localparam logic [1:0] COLOUR_GREEN  = 2'b10;

    function automatic logic is_green(input logic [1:0] colour);
        return colour == COLOUR_GREEN;
    endfunction

endpackage

// File: rtl/country_sensor_cond_loop_debounce.sv
// -----------------------------------------------------------------------------
// loop_debounce
// Synchronises the raw loop-detector signal into the clk domain, debounces it
// in units of tick and flags accepted level changes.
//
// Ports:
//   clk       in   system clock
//   reset     in   asynchronous, active-low reset
//   tick      in   timebase enable, one-cycle pulse
//   loop_raw  in   raw loop detector (asynchronous), 1 = vehicle present
//   deb_level out  debounced loop level
//   arrive    out  high for the cycle after deb_level goes 0->1
//   depart    out  high for the cycle after deb_level goes 1->0
// -----------------------------------------------------------------------------
module loop_debounce #(
    parameter int DEB_TICKS   = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic tick,
    input  logic loop_raw,
    output logic deb_level,
    output logic arrive,
    output logic depart
);

    // deb_cnt only has to reach DEB_TICKS-1
    localparam int DW = (DEB_TICKS > 1) ? $clog2(DEB_TICKS) : 1;
    localparam logic [DW-1:0] DEB_LAST = DW'(DEB_TICKS - 1);

    logic [SYNC_STAGES-1:0] sync_reg;
    logic [SYNC_STAGES-1:0] sync_next;
    logic                   loop_s;

    logic [DW-1:0] deb_cnt_reg;
    logic [DW-1:0] deb_cnt_next;
    logic          deb_level_reg;
    logic          deb_level_next;
    logic          deb_prev_reg;

    // Synchroniser chain: stage 0 samples the raw input, each further stage
    // re-samples the previous one.
    genvar gi;
    generate
        for (gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
            if (gi == 0) begin : g_first
                assign sync_next[gi] = loop_raw;
            end else begin : g_rest
                assign sync_next[gi] = sync_reg[gi-1];
            end
        end
    endgenerate

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_reg <= '0;
        end else begin
            sync_reg <= sync_next;
        end
    end

    assign loop_s = sync_reg[SYNC_STAGES-1];

    // Any tick on which the synchronised level agrees with the accepted level
    // restarts the persistence count, so only an unbroken run of DEB_TICKS
    // mismatching ticks changes deb_level.
    always_comb begin
        deb_cnt_next   = deb_cnt_reg;
        deb_level_next = deb_level_reg;
        if (loop_s == deb_level_reg) begin
            deb_cnt_next = '0;
        end else if (tick) begin
            if (deb_cnt_reg == DEB_LAST) begin
                deb_level_next = loop_s;
                deb_cnt_next   = '0;
            end else begin
                deb_cnt_next = deb_cnt_reg + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            deb_cnt_reg   <= '0;
            deb_level_reg <= 1'b0;
            deb_prev_reg  <= 1'b0;
        end else begin
            deb_cnt_reg   <= deb_cnt_next;
            deb_level_reg <= deb_level_next;
            deb_prev_reg  <= deb_level_reg;
        end
    end

    assign deb_level = deb_level_reg;
    assign arrive    = deb_level_reg & ~deb_prev_reg;
    assign depart    = ~deb_level_reg & deb_prev_reg;

endmodule

// File: rtl/country_sensor_cond.sv
// -----------------------------------------------------------------------------
// country_sensor_cond
// Vehicle-detector conditioner feeding the highway/country light controller.
// Debounces the country-road loop, counts queued vehicles and raises the
// controller's sensor request; while country green is served the request is
// held until traffic gaps out or the max-green limit is reached.
//
// Ports:
//   clk          in   system clock
//   reset        in   asynchronous, active-low reset
//   tick         in   timebase enable pulse; all timing is counted in ticks
//   loop_raw     in   raw loop detector (asynchronous), 1 = vehicle present
//   cntry_green  in   1 while the controller shows GREEN on the country road
//   sensor       out  registered request to the controller
//   veh_count    out  registered queued-vehicle count (saturating)
//   det_pulse    out  one-cycle pulse per accepted vehicle arrival
//   req_state    out  current FSM state (debug)
// -----------------------------------------------------------------------------
module country_sensor_cond
    import country_sensor_cond_pkg::*;
#(
    parameter int DEB_TICKS = 4,
    parameter int THRESH    = 2,
    parameter int MAX_WAIT  = 30,
    parameter int GAP       = 3,
    parameter int MAX_GREEN = 20,
    parameter int CNT_W     = 4,
    parameter int TMR_W     = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             tick,
    input  logic             loop_raw,
    input  logic             cntry_green,
    output logic             sensor,
    output logic [CNT_W-1:0] veh_count,
    output logic             det_pulse,
    output logic [1:0]       req_state
);

    localparam logic [CNT_W-1:0] CNT_MAX    = '1;
    localparam logic [CNT_W-1:0] CNT_THRESH = CNT_W'(THRESH);
    localparam logic [TMR_W-1:0] TMR_MAX    = '1;
    localparam logic [TMR_W-1:0] WAIT_LAST  = TMR_W'(MAX_WAIT - 1);
    localparam logic [TMR_W-1:0] GAP_LAST   = TMR_W'(GAP - 1);
    localparam logic [TMR_W-1:0] GREEN_LAST = TMR_W'(MAX_GREEN - 1);

    logic deb_level;
    logic arrive;
    logic depart_unused;   // departures do not affect the request logic

    logic [1:0]       state_reg;
    logic [1:0]       state_next;
    logic             sensor_reg;
    logic             sensor_next;
    logic             det_pulse_reg;
    logic [CNT_W-1:0] veh_count_reg;
    logic [CNT_W-1:0] veh_count_next;
    logic [TMR_W-1:0] wait_tmr_reg;
    logic [TMR_W-1:0] wait_tmr_next;
    logic [TMR_W-1:0] green_tmr_reg;
    logic [TMR_W-1:0] green_tmr_next;
    logic [TMR_W-1:0] gap_tmr_reg;
    logic [TMR_W-1:0] gap_tmr_next;
    logic             hold_exit;

    loop_debounce #(
        .DEB_TICKS   (DEB_TICKS),
        .SYNC_STAGES (2)
    ) u_loop_debounce (
        .clk       (clk),
        .reset     (reset),
        .tick      (tick),
        .loop_raw  (loop_raw),
        .deb_level (deb_level),
        .arrive    (arrive),
        .depart    (depart_unused)
    );

    // ---------------------------------------------------------------- state
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg  <= ST_IDLE;
            sensor_reg <= 1'b0;
        end else begin
            state_reg  <= state_next;
            sensor_reg <= sensor_next;
        end
    end

    // ------------------------------------------------------------ next state
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: begin
                if (veh_count_reg >= CNT_THRESH) begin
                    state_next = ST_REQUEST;
                end else if (veh_count_reg != '0) begin
                    state_next = ST_ARMED;
                end
            end
            ST_ARMED: begin
                if ((veh_count_reg >= CNT_THRESH) ||
                    (tick && (wait_tmr_reg == WAIT_LAST))) begin
                    state_next = ST_REQUEST;
                end
            end
            ST_REQUEST: begin
                if (cntry_green) begin
                    state_next = ST_HOLD;
                end
            end
            ST_HOLD: begin
                // The controller leaving green early ends the hold at once;
                // otherwise a gap-out needs the loop to be empty on that tick.
                if (!cntry_green) begin
                    state_next = ST_IDLE;
                end else if (tick && ((!deb_level && (gap_tmr_reg == GAP_LAST)) ||
                                      (green_tmr_reg == GREEN_LAST))) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // --------------------------------------------------------------- outputs
    // sensor is registered from the next state so it changes on the same edge
    // as state_reg.
    always_comb begin
        sensor_next = (state_next == ST_REQUEST) || (state_next == ST_HOLD);
    end

    // ---------------------------------------------------------------- timers
    always_comb begin
        wait_tmr_next  = '0;
        green_tmr_next = green_tmr_reg;
        gap_tmr_next   = gap_tmr_reg;

        if (state_reg == ST_ARMED) begin
            wait_tmr_next = wait_tmr_reg;
            if (tick && (wait_tmr_reg != TMR_MAX)) begin
                wait_tmr_next = wait_tmr_reg + 1'b1;
            end
        end

        if (state_reg == ST_HOLD) begin
            if (tick) begin
                if (green_tmr_reg != TMR_MAX) begin
                    green_tmr_next = green_tmr_reg + 1'b1;
                end
                if (deb_level) begin
                    gap_tmr_next = '0;
                end else if (gap_tmr_reg != TMR_MAX) begin
                    gap_tmr_next = gap_tmr_reg + 1'b1;
                end
            end
        end else begin
            // Outside HOLD both are parked at zero, so HOLD always starts fresh.
            green_tmr_next = '0;
            gap_tmr_next   = '0;
        end
    end

    // ------------------------------------------------------- vehicle counter
    assign hold_exit = (state_reg == ST_HOLD) && (state_next == ST_IDLE);

    always_comb begin
        veh_count_next = veh_count_reg;
        if (hold_exit) begin
            // Served queue is discarded; an arrival on the same cycle is lost
            // to the clear on purpose.
            veh_count_next = '0;
        end else if (arrive && (state_reg != ST_HOLD) && (veh_count_reg != CNT_MAX)) begin
            veh_count_next = veh_count_reg + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wait_tmr_reg  <= '0;
            green_tmr_reg <= '0;
            gap_tmr_reg   <= '0;
            veh_count_reg <= '0;
            det_pulse_reg <= 1'b0;
        end else begin
            wait_tmr_reg  <= wait_tmr_next;
            green_tmr_reg <= green_tmr_next;
            gap_tmr_reg   <= gap_tmr_next;
            veh_count_reg <= veh_count_next;
            det_pulse_reg <= arrive;
        end
    end

    assign sensor    = sensor_reg;
    assign veh_count = veh_count_reg;
    assign det_pulse = det_pulse_reg;
    assign req_state = state_reg;

endmodule

// File: doc/country_sensor_cond.md
Name: country_sensor_cond

Overview:
Vehicle-detector conditioner that sits directly upstream of the highway/country traffic-light controller and produces its `sensor` input. It takes the raw, asynchronous country-road loop-detector signal and synchronises and debounces it. It counts queued vehicles and decides when the country road is requested. While country green is being served, it holds the request until traffic gaps out or the max-green limit is reached.

Parameters:
DEB_TICKS, 4, consecutive ticks a new loop level must persist before it is accepted (>=1)
THRESH, 2, queued-vehicle count that raises the request immediately
MAX_WAIT, 30, ticks a single waiting vehicle may wait before the request is forced
GAP, 3, ticks with the loop empty during HOLD that end the request (gap-out)
MAX_GREEN, 20, ticks in HOLD after which the request is dropped regardless of traffic
CNT_W, 4, width of the vehicle counter
TMR_W, 8, width of the timers; must hold MAX_WAIT and MAX_GREEN

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low reset
tick  in  1  timebase enable, one-cycle pulse; all timing is in ticks
loop_raw  in  1  raw loop detector, asynchronous to clk, 1 = vehicle present
cntry_green  in  1  1 while the controller shows GREEN on the country road
sensor  out  1  request to the controller (registered)
veh_count  out  CNT_W  queued vehicles (registered)
det_pulse  out  1  one-cycle pulse per accepted vehicle arrival
req_state  out  2  current FSM state, for debug

Behaviour:
- Reset (async, reset=0) values:
  - sync flops, deb_level, all counters: 0
  - state: IDLE
  - sensor, det_pulse, veh_count: 0
- Synchroniser: two flops on loop_raw, giving loop_s.
- Debounce:
  - When loop_s == deb_level, deb_cnt clears to 0.
  - On a tick with loop_s != deb_level, deb_cnt increments.
  - On the tick where deb_cnt == DEB_TICKS-1 and a mismatch is present, deb_level <= loop_s and deb_cnt <= 0.
  - Latency from loop_raw change to deb_level change is 2 clk plus DEB_TICKS ticks.
  - A glitch shorter than DEB_TICKS ticks is ignored.
- Arrival and departure edges:
  - Arrival = deb_level 0->1; departure = deb_level 1->0.
  - det_pulse is 1 for exactly one cycle, the cycle after deb_level rises.
- veh_count:
  - Increments on each arrival in IDLE, ARMED or REQUEST.
  - Saturates at 2^CNT_W-1.
  - Arrivals in HOLD are not counted; those vehicles are served by the current green.
  - Clears to 0 on the HOLD->IDLE transition. If an arrival coincides with that transition, the clear wins.
- FSM (state encodings 00/01/10/11):
  - IDLE:
    - veh_count >= THRESH -> REQUEST
    - else veh_count > 0 -> ARMED
    - wait_tmr <= 0
  - ARMED:
    - wait_tmr increments per tick
    - veh_count >= THRESH, or wait_tmr reaching MAX_WAIT-1 on a tick -> REQUEST
  - REQUEST:
    - Holds until cntry_green == 1, then -> HOLD
    - green_tmr <= 0 and gap_tmr <= 0 on entry to HOLD
  - HOLD:
    - green_tmr increments per tick.
    - gap_tmr increments per tick while deb_level == 0 and clears while deb_level == 1.
    - gap_tmr reaching GAP-1 on a tick, or green_tmr reaching MAX_GREEN-1 on a tick -> IDLE.
    - cntry_green falling while in HOLD (early controller exit) -> IDLE.
- sensor:
  - Registered, updated in the same edge as the state.
  - sensor = 1 iff the new state is REQUEST or HOLD.
- Timers saturate and never wrap.
- tick held high means 1 tick per clk and must work correctly.
- Reset asserted mid-operation returns every output to its reset value asynchronously. After release, the block restarts in IDLE with the loop assumed empty. A vehicle already present is accepted as an arrival after debounce.

Decomposition:
- Shared package holds:
  - FSM state localparams (IDLE, ARMED, REQUEST, HOLD)
  - light-colour codes RED=00, YELLOW=01, GREEN=10, so the top decodes cntry_green from the controller's country output
- One natural sub-module: loop_debounce (synchroniser, debounce counter, edge detect). Its outputs are deb_level, arrive and depart.

Test Plan:
- tick=1 every clk, DEB_TICKS=4: loop_raw high for 3 clk then low.
  - Required: no det_pulse; veh_count stays 0; sensor stays 0.
- Single vehicle: loop_raw rises and stays.
  - Required: det_pulse 7 clk later (2 sync + 4 ticks + 1); veh_count=1; state ARMED.
  - Required: sensor rises exactly 30 ticks after ARMED entry.
- Two arrivals separated by 10 clk.
  - Required: veh_count=2 and sensor=1 on the cycle after the second count; no MAX_WAIT wait.
- In REQUEST, assert cntry_green with the loop empty.
  - Required: HOLD; sensor drops after 3 ticks (gap-out); veh_count returns to 0.
- In HOLD, toggle the loop so it never stays empty for 3 ticks.
  - Required: sensor drops exactly 20 ticks after HOLD entry (MAX_GREEN).
- Drive 20 arrivals with CNT_W=4.
  - Required: veh_count saturates at 15.
- Reset mid-HOLD.
  - Required: sensor, veh_count and det_pulse are 0 immediately, with no clock edge needed; state IDLE.
